// File: rtl/pc_stack_unit_pkg.sv
// Shared definitions for the fetch-stage PC generator: PC control codes and
// the default reset vector.
package pc_stack_unit_pkg;

    typedef enum logic [2:0] {
        PC_NOP  = 3'd0,
        PC_GOTO = 3'd1,
        PC_CALL = 3'd2,
        PC_RET  = 3'd3
    } pc_ctl_e;

    localparam logic [10:0] PC_RST_VEC = 11'h1FF;

endpackage

// File: rtl/pc_ret_stack.sv
// Circular hardware return stack: pushes past DEPTH overwrite the oldest entry,
// pops from empty still read the wrapped slot. Contents are never reset.
module pc_ret_stack #(
    parameter int W     = 11,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   sp_cnt,
    output logic                     ovf_evt,
    output logic                     unf_evt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;

    assign rp      = wp - AW'(1);
    assign dout    = mem[rp];
    assign full    = (sp_cnt == FULL_CNT);
    assign empty   = (sp_cnt == '0);
    assign ovf_evt = push & full;
    assign unf_evt = pop & empty;

    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= din;
    end

    // DEPTH is a power of two, so the pointer wraps by plain overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wp     <= '0;
            sp_cnt <= '0;
        end else if (push) begin
            wp <= wp + AW'(1);
            if (!full)
                sp_cnt <= sp_cnt + (AW+1)'(1);
        end else if (pop) begin
            wp <= rp;
            if (!empty)
                sp_cnt <= sp_cnt - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Registered program counter with next-PC selection, return stack and sticky
// overflow/underflow flags for the clairisc fetch stage.
module pc_stack_unit
    import pc_stack_unit_pkg::*;
#(
    parameter int          PC_W    = 11,
    parameter int          DEPTH   = 2,
    parameter logic [10:0] RST_VEC = PC_RST_VEC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [2:0]             ctl,
    input  logic [11:0]            ins,
    input  logic [1:0]             pa,
    input  logic                   skip,
    input  logic                   clr_flags,
    output logic [PC_W-1:0]        pc,
    output logic [$clog2(DEPTH):0] sp_cnt,
    output logic                   ovf,
    output logic                   unf
);

    logic [PC_W-1:0] inc;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] stk_dout;
    logic            push_req;
    logic            pop_req;
    logic            stk_full;
    logic            stk_empty;
    logic            ovf_evt;
    logic            unf_evt;
    logic            unused_ok;

    assign unused_ok = ^{ins[11:9], stk_full, stk_empty};
    assign inc       = pc + PC_W'(1);

    // skip outranks every control code, including CALL and RET
    always_comb begin
        push_req = 1'b0;
        pop_req  = 1'b0;
        pc_nxt   = inc;
        if (!skip) begin
            case (ctl)
                PC_GOTO: pc_nxt = PC_W'({pa, ins[8:0]});
                PC_CALL: begin
                    push_req = 1'b1;
                    pc_nxt   = PC_W'({pa, 1'b0, ins[7:0]});
                end
                PC_RET: begin
                    pop_req = 1'b1;
                    pc_nxt  = stk_dout;
                end
                default: pc_nxt = inc;
            endcase
        end
    end

    pc_ret_stack #(
        .W     (PC_W),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push    (en & push_req),
        .pop     (en & pop_req),
        .din     (inc),
        .dout    (stk_dout),
        .full    (stk_full),
        .empty   (stk_empty),
        .sp_cnt  (sp_cnt),
        .ovf_evt (ovf_evt),
        .unf_evt (unf_evt)
    );

    always_ff @(posedge clk) begin
        if (rst)
            pc <= PC_W'(RST_VEC);
        else if (en)
            pc <= pc_nxt;
    end

    // clr_flags works even while stalled; a coincident new event wins
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= (ovf & ~clr_flags) | ovf_evt;
            unf <= (unf & ~clr_flags) | unf_evt;
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural stack model.
module tb_pc_stack_unit;

    localparam int PC_W  = 11;
    localparam int DEPTH = 2;
    localparam int MASK  = (1 << PC_W) - 1;

    logic                   clk;
    logic                   rst;
    logic                   en;
    logic [2:0]             ctl;
    logic [11:0]            ins;
    logic [1:0]             pa;
    logic                   skip;
    logic                   clr_flags;
    logic [PC_W-1:0]        pc;
    logic [$clog2(DEPTH):0] sp_cnt;
    logic                   ovf;
    logic                   unf;

    pc_stack_unit #(
        .PC_W    (PC_W),
        .DEPTH   (DEPTH),
        .RST_VEC (11'h1FF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ctl       (ctl),
        .ins       (ins),
        .pa        (pa),
        .skip      (skip),
        .clr_flags (clr_flags),
        .pc        (pc),
        .sp_cnt    (sp_cnt),
        .ovf       (ovf),
        .unf       (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mdl_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stack as an unbounded-pointer ring plus a queue of live entries
    int m_pc;
    int m_wp;
    int m_mem [DEPTH];
    int m_q[$];
    bit m_ovf;
    bit m_unf;

    function automatic int slot(input int w);
        return ((w % DEPTH) + DEPTH) % DEPTH;
    endfunction

    always @(posedge clk) begin
        bit ovf_e;
        bit unf_e;
        int nxt;
        ovf_e = 1'b0;
        unf_e = 1'b0;
        if (rst) begin
            m_pc  = 'h1FF;
            m_wp  = 0;
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (en) begin
                nxt = (m_pc + 1) & MASK;
                if (!skip) begin
                    if (ctl == 3'd1) begin
                        nxt = (int'(pa) << 9) | int'(ins[8:0]);
                    end else if (ctl == 3'd2) begin
                        m_mem[slot(m_wp)] = nxt;
                        m_wp++;
                        m_q.push_back(nxt);
                        if (m_q.size() > DEPTH) begin
                            void'(m_q.pop_front());
                            ovf_e = 1'b1;
                        end
                        nxt = (int'(pa) << 9) | int'(ins[7:0]);
                    end else if (ctl == 3'd3) begin
                        m_wp--;
                        nxt = m_mem[slot(m_wp)];
                        if (m_q.size() > 0) void'(m_q.pop_back());
                        else unf_e = 1'b1;
                    end
                end
                m_pc = nxt;
            end
            if (clr_flags) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (ovf_e) m_ovf = 1'b1;
            if (unf_e) m_unf = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            chk("mdl_pc", int'(pc), m_pc);
            chk("mdl_sp_cnt", int'(sp_cnt), m_q.size());
            chk("mdl_ovf", int'(ovf), int'(m_ovf));
            chk("mdl_unf", int'(unf), int'(m_unf));
        end
    end

    task automatic cyc(input logic r, input logic e, input logic [2:0] c,
                       input logic [1:0] p, input logic [11:0] i,
                       input logic s, input logic cf);
        rst       = r;
        en        = e;
        ctl       = c;
        pa        = p;
        ins       = i;
        skip      = s;
        clr_flags = cf;
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int addr);
        cyc(1'b0, 1'b1, 3'd1, 2'((addr >> 9) & 3), 12'(addr & 'h1FF), 1'b0, 1'b0);
    endtask

    task automatic op(input logic [2:0] c, input int i, input logic cf);
        cyc(1'b0, 1'b1, c, 2'b00, 12'(i), 1'b0, cf);
    endtask

    initial begin
        cyc(1'b1, 1'b1, 3'd0, 2'b00, 12'h000, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 3'd0, 2'b00, 12'h000, 1'b0, 1'b0);
        mdl_on = 1'b1;
        chk("rst_pc", int'(pc), 'h1FF);
        chk("rst_sp", int'(sp_cnt), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_unf", int'(unf), 0);

        repeat (3) cyc(1'b0, 1'b0, 3'd1, 2'b01, 12'h123, 1'b0, 1'b0);
        chk("stall_pc", int'(pc), 'h1FF);

        go('h010);
        chk("goto_pc", int'(pc), 'h010);
        cyc(1'b0, 1'b1, 3'd2, 2'b01, 12'h1A5, 1'b0, 1'b0);
        chk("call_pc", int'(pc), 'h2A5);
        chk("call_sp", int'(sp_cnt), 1);
        op(3'd3, 0, 1'b0);
        chk("ret_pc", int'(pc), 'h011);
        chk("ret_sp", int'(sp_cnt), 0);

        go('h000); op(3'd2, 'h055, 1'b0);
        go('h100); op(3'd2, 'h055, 1'b0);
        go('h200); op(3'd2, 'h055, 1'b0);
        chk("ovf_flag", int'(ovf), 1);
        chk("ovf_sp", int'(sp_cnt), 2);
        op(3'd3, 0, 1'b0);
        chk("ovf_ret1", int'(pc), 'h201);
        op(3'd3, 0, 1'b0);
        chk("ovf_ret2", int'(pc), 'h101);

        op(3'd3, 0, 1'b0);
        chk("unf_flag", int'(unf), 1);
        chk("unf_sp", int'(sp_cnt), 0);
        op(3'd3, 0, 1'b1);
        chk("unf_set_wins", int'(unf), 1);
        op(3'd0, 0, 1'b1);
        chk("unf_cleared", int'(unf), 0);

        go('h050);
        cyc(1'b0, 1'b1, 3'd2, 2'b00, 12'h0AA, 1'b1, 1'b0);
        chk("skip_pc", int'(pc), 'h051);
        chk("skip_sp", int'(sp_cnt), 0);

        go('h7FF);
        op(3'd0, 0, 1'b0);
        chk("wrap_pc", int'(pc), 'h000);

        op(3'd2, 'h011, 1'b0);
        op(3'd2, 'h022, 1'b0);
        op(3'd2, 'h033, 1'b0);
        cyc(1'b1, 1'b1, 3'd3, 2'b00, 12'h000, 1'b0, 1'b0);
        chk("midrst_pc", int'(pc), 'h1FF);
        chk("midrst_sp", int'(sp_cnt), 0);
        chk("midrst_ovf", int'(ovf), 0);

        for (int n = 0; n < 3000; n++) begin
            cyc(logic'($urandom_range(0, 99) == 0),
                logic'($urandom_range(0, 9) != 0),
                3'($urandom_range(0, 7)),
                2'($urandom_range(0, 3)),
                12'($urandom_range(0, 4095)),
                logic'($urandom_range(0, 9) == 0),
                logic'($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        mdl_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
